iq_issue_scheduler: RTL and testbench

Issue scheduler for the scheduling-stage instruction queue. It owns slot allocation, per-slot valid/operand-ready tracking, tag wakeup from writeback, and oldest-ready-first selection of one entry per cycle toward the ALU pipeline. The payload array (`Instr_Queue_Entry_t` storage) stays in the queue. This block supplies the write slot index, the issue slot index and the valid-bit sequencing that the queue's storage needs.

---
 rtl/iq_issue_scheduler_pkg.sv | 26 ++
 rtl/iq_age_matrix.sv | 54 +++++
 rtl/iq_issue_scheduler.sv | 121 ++++++++++++
 tb/tb_iq_issue_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/iq_issue_scheduler_pkg.sv
// Shared types for the issue-queue scheduler: queue depth, phys tag width, per-slot state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package iq_issue_scheduler_pkg;

   localparam int INSTR_QUEUE_SIZE = 8;
   localparam int IQ_PHYS_TAG_W    = 6;

   typedef logic [IQ_PHYS_TAG_W-1:0] phys_tag_t;

   typedef struct packed {
      logic      valid;
      logic      src1_rdy;
      logic      src2_rdy;
      phys_tag_t src1_tag;
      phys_tag_t src2_tag;
   } iq_slot_state_t;

   // Source is ready at allocation if rename says so, or the producing tag
   // is being broadcast in the very same cycle.
   function automatic logic src_ready_at_alloc(input logic rdy, input phys_tag_t tag,
                                               input logic wb_vld, input phys_tag_t wb_tag);
      return rdy || (wb_vld && (wb_tag == tag));
   endfunction

endpackage

// File: rtl/iq_age_matrix.sv
// Age matrix: tracks relative allocation order and picks the oldest ready slot (one-hot).
// Latency: pick is combinational from registered age state; updates at the rising edge.
// Backpressure: none; the caller qualifies alloc/issue fires.
// Ports: clk/rst_n (sync active-low), clear (flush), alloc_fire/alloc_oh, valid (pre-edge),
//        issue_fire/issue_oh, ready (candidate vector), pick_oh (oldest ready, one-hot).
module iq_age_matrix #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         alloc_fire,
   input  logic [N-1:0] alloc_oh,
   input  logic [N-1:0] valid,
   input  logic         issue_fire,
   input  logic [N-1:0] issue_oh,
   input  logic [N-1:0] ready,
   output logic [N-1:0] pick_oh
);

   // older[i][j] = 1 : slot i was allocated before slot j
   logic [N-1:0] older [N];

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         for (int i = 0; i < N; i++) older[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               // The issued slot leaves the ordering entirely; it can never be
               // the allocated slot since allocation only uses free slots.
               if (issue_fire && (issue_oh[i] || issue_oh[j]))
                  older[i][j] <= 1'b0;
               else if (alloc_fire && alloc_oh[i])
                  older[i][j] <= 1'b0;
               else if (alloc_fire && alloc_oh[j])
                  older[i][j] <= valid[i];
            end
         end
      end
   end

   // A ready slot wins unless some other ready slot is older than it.
   always_comb begin
      pick_oh = '0;
      for (int i = 0; i < N; i++) begin
         pick_oh[i] = ready[i];
         for (int j = 0; j < N; j++) begin
            if (ready[j] && older[j][i]) pick_oh[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/iq_issue_scheduler.sv
// Issue scheduler: slot allocation, operand wakeup and oldest-ready-first selection.
// Latency: alloc/wakeup at edge N -> issue_valid in cycle N+1; outputs are from registered state.
// Backpressure: issue_ready low holds entries; alloc_ready low when full, flushing or in reset.
// Ports: alloc_* (dispatch handshake + source tags/ready, alloc_slot out), wb_valid/wb_tag
//        (wakeup broadcast), issue_valid/issue_slot/issue_ready (ALU handshake), flush, occupancy.
module iq_issue_scheduler
   import iq_issue_scheduler_pkg::*;
#(
   parameter int INSTR_QUEUE_SIZE = iq_issue_scheduler_pkg::INSTR_QUEUE_SIZE,
   parameter int PHYS_TAG_W       = IQ_PHYS_TAG_W,
   parameter int SLOT_W           = $clog2(INSTR_QUEUE_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alloc_valid,
   output logic                  alloc_ready,
   output logic [SLOT_W-1:0]     alloc_slot,
   input  logic [PHYS_TAG_W-1:0] alloc_src1_tag,
   input  logic [PHYS_TAG_W-1:0] alloc_src2_tag,
   input  logic                  alloc_src1_rdy,
   input  logic                  alloc_src2_rdy,
   input  logic                  wb_valid,
   input  logic [PHYS_TAG_W-1:0] wb_tag,
   output logic                  issue_valid,
   output logic [SLOT_W-1:0]     issue_slot,
   input  logic                  issue_ready,
   input  logic                  flush,
   output logic [SLOT_W:0]       occupancy
);

   localparam int N = INSTR_QUEUE_SIZE;

   iq_slot_state_t slot_q [N];
   logic [SLOT_W:0] occ_q;

   logic [N-1:0] valid_vec, ready_vec, alloc_oh, pick_oh;
   logic         alloc_fire, issue_fire;

   // Tags are held at the package width; PHYS_TAG_W must not exceed it.
   phys_tag_t wb_tag_p, src1_tag_p, src2_tag_p;
   assign wb_tag_p   = phys_tag_t'(wb_tag);
   assign src1_tag_p = phys_tag_t'(alloc_src1_tag);
   assign src2_tag_p = phys_tag_t'(alloc_src2_tag);

   always_comb begin
      valid_vec = '0;
      ready_vec = '0;
      for (int i = 0; i < N; i++) begin
         valid_vec[i] = slot_q[i].valid;
         ready_vec[i] = slot_q[i].valid && slot_q[i].src1_rdy && slot_q[i].src2_rdy;
      end
   end

   // Lowest-index free slot; scanning downward leaves the lowest one last.
   always_comb begin
      alloc_slot = '0;
      alloc_oh   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!valid_vec[i]) begin
            alloc_slot = SLOT_W'(i);
            alloc_oh   = '0;
            alloc_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      issue_slot = '0;
      for (int i = 0; i < N; i++) begin
         if (pick_oh[i]) issue_slot = SLOT_W'(i);
      end
   end

   assign issue_valid = |ready_vec;
   assign occupancy   = occ_q;
   assign alloc_ready = (occ_q < (SLOT_W+1)'(N)) && !flush && rst_n;
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign issue_fire  = issue_valid && issue_ready;

   iq_age_matrix #(.N(N)) u_age (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (flush),
      .alloc_fire (alloc_fire),
      .alloc_oh   (alloc_oh),
      .valid      (valid_vec),
      .issue_fire (issue_fire),
      .issue_oh   (pick_oh),
      .ready      (ready_vec),
      .pick_oh    (pick_oh)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) slot_q[i] <= '0;
         occ_q <= '0;
      end else if (flush) begin
         // Flush wins over same-cycle alloc/issue; the queue drops both.
         for (int i = 0; i < N; i++) slot_q[i].valid <= 1'b0;
         occ_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (wb_valid && slot_q[i].valid && slot_q[i].src1_tag == wb_tag_p)
               slot_q[i].src1_rdy <= 1'b1;
            if (wb_valid && slot_q[i].valid && slot_q[i].src2_tag == wb_tag_p)
               slot_q[i].src2_rdy <= 1'b1;
            if (issue_fire && pick_oh[i])
               slot_q[i].valid <= 1'b0;
            if (alloc_fire && alloc_oh[i]) begin
               slot_q[i].valid    <= 1'b1;
               slot_q[i].src1_tag <= src1_tag_p;
               slot_q[i].src2_tag <= src2_tag_p;
               slot_q[i].src1_rdy <= src_ready_at_alloc(alloc_src1_rdy, src1_tag_p, wb_valid, wb_tag_p);
               slot_q[i].src2_rdy <= src_ready_at_alloc(alloc_src2_rdy, src2_tag_p, wb_valid, wb_tag_p);
            end
         end
         occ_q <= occ_q + (SLOT_W+1)'(alloc_fire) - (SLOT_W+1)'(issue_fire);
      end
   end

endmodule

// File: tb/tb_iq_issue_scheduler.sv
// Bench for iq_issue_scheduler: directed scenarios plus random traffic against an age-stamp model.
module tb_iq_issue_scheduler;

   localparam int N = 8;

   logic       clk;
   logic       rst_n;
   logic       alloc_valid;
   logic       alloc_ready;
   logic [2:0] alloc_slot;
   logic [5:0] alloc_src1_tag, alloc_src2_tag;
   logic       alloc_src1_rdy, alloc_src2_rdy;
   logic       wb_valid;
   logic [5:0] wb_tag;
   logic       issue_valid;
   logic [2:0] issue_slot;
   logic       issue_ready;
   logic       flush;
   logic [3:0] occupancy;

   iq_issue_scheduler dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .alloc_valid    (alloc_valid),
      .alloc_ready    (alloc_ready),
      .alloc_slot     (alloc_slot),
      .alloc_src1_tag (alloc_src1_tag),
      .alloc_src2_tag (alloc_src2_tag),
      .alloc_src1_rdy (alloc_src1_rdy),
      .alloc_src2_rdy (alloc_src2_rdy),
      .wb_valid       (wb_valid),
      .wb_tag         (wb_tag),
      .issue_valid    (issue_valid),
      .issue_slot     (issue_slot),
      .issue_ready    (issue_ready),
      .flush          (flush),
      .occupancy      (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: each live slot carries an allocation stamp; oldest = smallest stamp.
   bit       m_v  [N];
   bit       m_r1 [N];
   bit       m_r2 [N];
   bit [5:0] m_t1 [N];
   bit [5:0] m_t2 [N];
   int       m_age[N];
   int       seq = 0;

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_v[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
      end
   endtask

   // Drive one cycle of inputs, check the outputs against the model, advance the model past the edge.
   task automatic step(input bit av, input bit [5:0] t1, input bit r1, input bit [5:0] t2,
                       input bit r2, input bit wv, input bit [5:0] wt, input bit ir,
                       input bit fl, input bit rn);
      int  occ, free, sel;
      bit  e_ar, afire, ifire;
      alloc_valid = av; alloc_src1_tag = t1; alloc_src1_rdy = r1;
      alloc_src2_tag = t2; alloc_src2_rdy = r2; wb_valid = wv; wb_tag = wt;
      issue_ready = ir; flush = fl; rst_n = rn;
      #1;
      occ = 0; free = -1; sel = -1;
      for (int i = 0; i < N; i++) begin
         if (m_v[i]) occ++;
         else if (free < 0) free = i;
         if (m_v[i] && m_r1[i] && m_r2[i] && (sel < 0 || m_age[i] < m_age[sel])) sel = i;
      end
      e_ar = (occ < N) && !fl && rn;
      chk("alloc_ready", alloc_ready, e_ar);
      chk("occupancy", occupancy, occ);
      chk("issue_valid", issue_valid, sel >= 0);
      chk("issue_slot", issue_slot, (sel < 0) ? 0 : sel);
      if (occ < N) chk("alloc_slot", alloc_slot, free);

      afire = av && e_ar;
      ifire = (sel >= 0) && ir;
      if (!rn || fl) begin
         model_clear();
      end else begin
         if (wv) begin
            for (int i = 0; i < N; i++) begin
               if (m_v[i] && m_t1[i] == wt) m_r1[i] = 1;
               if (m_v[i] && m_t2[i] == wt) m_r2[i] = 1;
            end
         end
         if (ifire) m_v[sel] = 0;
         if (afire) begin
            m_v[free]   = 1;
            m_t1[free]  = t1;
            m_t2[free]  = t2;
            m_r1[free]  = r1 || (wv && wt == t1);
            m_r2[free]  = r2 || (wv && wt == t2);
            m_age[free] = seq++;
         end
      end
      @(negedge clk);
   endtask

   // Shorthands: allocate (no issue), and idle with a given issue_ready.
   task automatic do_alloc(input bit [5:0] t1, input bit r1, input bit [5:0] t2, input bit r2);
      step(1, t1, r1, t2, r2, 0, 6'd63, 0, 0, 1);
   endtask

   task automatic idle(input bit ir);
      step(0, 0, 0, 0, 0, 0, 6'd63, ir, 0, 1);
   endtask

   localparam bit [5:0] NR = 6'd50;

   initial begin
      alloc_valid = 0; alloc_src1_tag = 0; alloc_src2_tag = 0; alloc_src1_rdy = 0;
      alloc_src2_rdy = 0; wb_valid = 0; wb_tag = 0; issue_ready = 0; flush = 0;
      rst_n = 0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state and in-order drain of three ready entries.
      idle(0);
      repeat (3) do_alloc(0, 1, 0, 1);
      repeat (3) idle(1);
      chk("drain_occ", occupancy, 0);

      // Younger ready entry overtakes an older waiting one; broadcast wakes the older.
      do_alloc(6'd5, 0, 0, 1);
      do_alloc(0, 1, 0, 1);
      step(0, 0, 0, 0, 0, 1, 6'd5, 1, 0, 1);
      chk("wakeup_iv", issue_valid, 1);
      chk("wakeup_slot", issue_slot, 0);
      idle(1);
      idle(1);

      // Same-cycle bypass on source 2.
      step(1, 0, 1, 6'd9, 0, 1, 6'd9, 0, 0, 1);
      chk("bypass_iv", issue_valid, 1);
      idle(1);

      // Fill the queue, only slot 3 ready; issuing it frees slot 3 next cycle.
      for (int i = 0; i < N; i++) do_alloc(NR, i == 3, 0, 1);
      chk("full_ready", alloc_ready, 0);
      step(1, 0, 1, 0, 1, 0, 6'd63, 1, 0, 1);
      chk("reuse_ready", alloc_ready, 1);
      chk("reuse_slot", alloc_slot, 3);
      step(0, 0, 0, 0, 0, 0, 6'd63, 0, 1, 1);

      // Stall with two ready entries, then release.
      do_alloc(0, 1, 0, 1);
      do_alloc(0, 1, 0, 1);
      repeat (4) idle(0);
      chk("stall_occ", occupancy, 2);
      idle(1);
      idle(1);

      // Flush with concurrent alloc and issue fires.
      do_alloc(0, 1, 0, 1);
      do_alloc(0, 1, 0, 1);
      step(1, 0, 1, 0, 1, 0, 6'd63, 1, 1, 1);
      chk("flush_occ", occupancy, 0);
      chk("flush_iv", issue_valid, 0);

      // Reset mid-stream.
      do_alloc(0, 1, 0, 1);
      do_alloc(0, 1, 0, 1);
      step(1, 0, 1, 0, 1, 0, 6'd63, 1, 0, 0);
      rst_n = 1;
      #1;
      chk("rst_occ", occupancy, 0);
      chk("rst_iv", issue_valid, 0);
      chk("rst_ar", alloc_ready, 1);

      // Random traffic with a small tag space so wakeups and bypasses hit often.
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 3) != 0,
              6'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
              6'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 59) == 0,
              $urandom_range(0, 99) != 0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
